// File: rtl/ldpc_decoder.sv
// Hard-decision bit-flipping LDPC decoder over interleaved parity checks (check j covers j, j+M, ...).
// Optional macro LDPC_EARLY_STOP_EN: end decoding after the first pass with no failing check.
module ldpc_decoder #(
  parameter int D_WID = 6,
  parameter int N_LEN = 9216
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [D_WID-1:0] data_in,
  input  logic             sync_in,
  input  logic             rate,
  input  logic [4:0]       max_iter,
  output logic             data_out,
  output logic             sync_out,
  output logic             busy,
  output logic [4:0]       num_iter
);
  localparam int AW = $clog2(N_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_LEN - 1);
  localparam logic [AW-1:0] M_HALF   = AW'(N_LEN / 2);
  localparam logic [AW-1:0] M_QTR    = AW'(N_LEN / 4);
  localparam logic [AW-1:0] K_HALF   = AW'(N_LEN / 2);
  localparam logic [AW-1:0] K_3Q     = AW'(N_LEN - N_LEN / 4);

  typedef enum logic [1:0] {IDLE, LOAD, DECODE, OUTPUT} state_t;
  state_t state, state_next;

  logic             hard_mem [N_LEN];
  logic [D_WID-1:0] mag_mem  [N_LEN];

  logic [AW-1:0]    cnt, chk, addr, min_idx, m_len, k_len, rd_addr, wr_addr;
  logic [2:0]       mem_idx, deg;
  logic [D_WID-1:0] min_mag, mag_in, mag_rd;
  logic             rate_q, parity, hard_rd, write_phase, pass_end, stop, load_en, flip_en;
  logic [4:0]       max_iter_q, iter_cnt, iter_next;
`ifdef LDPC_EARLY_STOP_EN
  logic             flip_seen, pass_flip;
`endif

  always_comb begin
    m_len       = rate_q ? M_QTR : M_HALF;
    k_len       = rate_q ? K_3Q : K_HALF;
    deg         = rate_q ? 3'd4 : 3'd2;
    mag_in      = data_in[D_WID-1] ? (~data_in) + D_WID'(1) : data_in;
    rd_addr     = (state == OUTPUT) ? cnt : addr;
    wr_addr     = (state == IDLE) ? '0 : cnt;
    hard_rd     = hard_mem[rd_addr];
    mag_rd      = mag_mem[addr];
    write_phase = (mem_idx == deg);
    pass_end    = (state == DECODE) && write_phase && (chk == m_len - AW'(1));
    load_en     = !reset_n && sync_in && ((state == IDLE) || (state == LOAD));
    flip_en     = !reset_n && (state == DECODE) && write_phase && parity;
`ifdef LDPC_EARLY_STOP_EN
    pass_flip   = flip_seen | parity;
    iter_next   = pass_flip ? iter_cnt + 5'd1 : iter_cnt;
    stop        = !pass_flip || (iter_next == max_iter_q);
`else
    iter_next   = iter_cnt + 5'd1;
    stop        = (iter_next == max_iter_q);
`endif
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (sync_in) state_next = LOAD;
      LOAD: begin
        if (!sync_in)               state_next = IDLE;
        else if (cnt == LAST_IDX)   state_next = (max_iter_q == 5'd0) ? OUTPUT : DECODE;
      end
      DECODE:  if (pass_end && stop) state_next = OUTPUT;
      OUTPUT:  if (cnt == k_len)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) state <= IDLE;
    else         state <= state_next;
  end

  // Sample storage and in-place bit flips; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      hard_mem[wr_addr] <= data_in[D_WID-1];
      mag_mem[wr_addr]  <= mag_in;
    end
    if (flip_en) hard_mem[min_idx] <= ~hard_mem[min_idx];
  end

  // Each check spends deg cycles reading its members and one cycle applying the flip.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      busy <= 1'b0; sync_out <= 1'b0; data_out <= 1'b0; num_iter <= '0;
      cnt <= '0; chk <= '0; addr <= '0; mem_idx <= '0; iter_cnt <= '0;
      parity <= 1'b0; min_mag <= '0; min_idx <= '0; rate_q <= 1'b0; max_iter_q <= '0;
`ifdef LDPC_EARLY_STOP_EN
      flip_seen <= 1'b0;
`endif
    end else begin
      sync_out <= 1'b0;
      data_out <= 1'b0;
      unique case (state)
        IDLE: if (sync_in) begin
          cnt <= AW'(1); rate_q <= rate; max_iter_q <= max_iter;
          busy <= 1'b1; iter_cnt <= '0;
        end
        LOAD: begin
          if (!sync_in) begin
            busy <= 1'b0; cnt <= '0;
          end else if (cnt == LAST_IDX) cnt <= '0;
          else cnt <= cnt + AW'(1);
        end
        DECODE: begin
          if (write_phase) begin
            parity <= 1'b0; mem_idx <= '0;
            if (pass_end) begin
              chk <= '0; addr <= '0; iter_cnt <= iter_next;
            end else begin
              chk <= chk + AW'(1); addr <= chk + AW'(1);
            end
`ifdef LDPC_EARLY_STOP_EN
            flip_seen <= pass_end ? 1'b0 : pass_flip;
`endif
          end else begin
            parity  <= parity ^ hard_rd;
            mem_idx <= mem_idx + 3'd1;
            addr    <= addr + m_len;
            if ((mem_idx == 3'd0) || (mag_rd < min_mag)) begin
              min_mag <= mag_rd; min_idx <= addr;
            end
          end
        end
        OUTPUT: begin
          if (cnt == k_len) begin
            busy <= 1'b0; cnt <= '0;
          end else begin
            sync_out <= 1'b1; data_out <= hard_rd; cnt <= cnt + AW'(1);
            if (cnt == '0) num_iter <= iter_cnt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ldpc_decoder.sv
// Scoreboard bench for ldpc_decoder: directed and random frames checked against a bit-flipping reference model.
module tb_ldpc_decoder;
  localparam int D_WID = 6;
  localparam int N_LEN = 192;
`ifdef LDPC_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [D_WID-1:0] data_in;
  logic             sync_in;
  logic             rate;
  logic [4:0]       max_iter;
  logic             data_out;
  logic             sync_out;
  logic             busy;
  logic [4:0]       num_iter;

  always #5 clk = ~clk;

  ldpc_decoder #(.D_WID(D_WID), .N_LEN(N_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .sync_in(sync_in),
    .rate(rate), .max_iter(max_iter), .data_out(data_out), .sync_out(sync_out),
    .busy(busy), .num_iter(num_iter)
  );

  typedef struct packed { int k; int iters; int lat; } frame_t;
  frame_t frame_q[$];
  bit     bit_q[$];
  int     llr [N_LEN];
  int     checks = 0;
  int     passes = 0;
  int     edge_cnt = 0;
  int     last_edge = 0;
  int     last_iters = 0;
  bit     flush = 1'b0;
  bit     mon_active = 1'b0;
  frame_t cur;
  int     bit_idx = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic fillConst(input int v);
    for (int i = 0; i < N_LEN; i++) llr[i] = v;
  endtask

  // Reference: visit every check, flip the weakest member of each odd check, repeat.
  task automatic runModel(input bit r, input int mi, output frame_t f);
    bit hard [N_LEN];
    int mag  [N_LEN];
    int m, p, it, flips, best, par;
    m = r ? N_LEN / 4 : N_LEN / 2;
    for (int i = 0; i < N_LEN; i++) begin
      hard[i] = (llr[i] < 0);
      mag[i]  = (llr[i] < 0) ? -llr[i] : llr[i];
    end
    p = 0; it = 0;
    while (it < mi) begin
      flips = 0;
      for (int j = 0; j < m; j++) begin
        par = 0; best = j;
        for (int i = j; i < N_LEN; i += m) begin
          par = par ^ int'(hard[i]);
          if (mag[i] < mag[best]) best = i;
        end
        if (par != 0) begin hard[best] = !hard[best]; flips++; end
      end
      p++;
      if (EARLY && flips == 0) break;
      it++;
    end
    f.k = N_LEN - m;
    f.iters = it;
    f.lat = p * (N_LEN + m) + 1;
    for (int i = 0; i < f.k; i++) bit_q.push_back(hard[i]);
  endtask

  task automatic applyStimulus(input bit r, input int mi, input int n_send);
    frame_t f;
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 20000) begin @(negedge clk); guard++; end
    checkOutput("busy_before_frame", busy, 0);
    if (n_send == N_LEN) begin
      runModel(r, mi, f);
      frame_q.push_back(f);
    end
    for (int i = 0; i < n_send; i++) begin
      sync_in = 1'b1;
      data_in = D_WID'(llr[i]);
      if (i == 0) begin rate = r; max_iter = 5'(mi); end
      else begin rate = 1'($urandom); max_iter = 5'($urandom); end
      @(negedge clk);
    end
    if (n_send == N_LEN) begin
      last_edge = edge_cnt;
      last_iters = f.iters;
      for (int i = 0; i < 3; i++) begin
        data_in = D_WID'($urandom);
        @(negedge clk);
      end
      sync_in = 1'b0;
    end else begin
      checkOutput("busy_during_load", busy, 1);
      sync_in = 1'b0;
      @(posedge clk); #2;
      checkOutput("busy_after_abort", busy, 0);
      checkOutput("num_iter_after_abort", num_iter, last_iters);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents output.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (flush) begin
        mon_active = 1'b0;
        bit_q.delete();
        frame_q.delete();
      end else if (sync_out) begin
        if (!mon_active) begin
          checkOutput("frame_expected", frame_q.size(), 1);
          if (frame_q.size() > 0) begin
            cur = frame_q.pop_front();
            mon_active = 1'b1;
            bit_idx = 0;
            checkOutput("first_sync_latency", edge_cnt - last_edge, cur.lat);
            checkOutput("num_iter", num_iter, cur.iters);
          end
        end
        if (mon_active) begin
          if (bit_q.size() > 0) checkOutput($sformatf("data_out[%0d]", bit_idx), data_out, bit_q.pop_front());
          else checkOutput("bit_available", bit_q.size(), 1);
          bit_idx++;
        end
      end else begin
        checkOutput("data_out_idle", data_out, 0);
        if (mon_active) begin
          checkOutput("bit_count", bit_idx, cur.k);
          checkOutput("busy_after_last", busy, 0);
          checkOutput("num_iter_hold", num_iter, cur.iters);
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    int guard;
    reset_n = 1'b1; sync_in = 1'b0; data_in = '0; rate = 1'b0; max_iter = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sync_out", sync_out, 0);
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_num_iter", num_iter, 0);
    @(negedge clk) reset_n = 1'b0;

    fillConst(20);                            applyStimulus(1'b0, 20, N_LEN);
    fillConst(20); llr[5] = -3;               applyStimulus(1'b0, 20, N_LEN);
    fillConst(20);                            applyStimulus(1'b0, 20, 100);
    fillConst(20);                            applyStimulus(1'b0, 20, N_LEN);
    fillConst(20); llr[10] = -31; llr[58] = 1; applyStimulus(1'b1, 20, N_LEN);
    fillConst(20); llr[7] = -1;               applyStimulus(1'b0, 0, N_LEN);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N_LEN; i++)
        llr[i] = (f % 2 == 1) ? int'($urandom_range(0, 63)) - 32 : int'($urandom_range(0, 7)) - 4;
      applyStimulus(1'($urandom), int'($urandom_range(0, 3)), N_LEN);
    end

    fillConst(20); llr[3] = -5;
    applyStimulus(1'b0, 2, N_LEN);
    guard = 0;
    while (!sync_out && guard < 5000) begin @(negedge clk); guard++; end
    checkOutput("reached_output", sync_out, 1);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    reset_n = 1'b1;
    @(posedge clk); #2;
    checkOutput("midreset_sync_out", sync_out, 0);
    checkOutput("midreset_data_out", data_out, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_num_iter", num_iter, 0);
    @(negedge clk);
    reset_n = 1'b0;
    flush = 1'b0;

    fillConst(20); llr[40] = -9; applyStimulus(1'b1, 3, N_LEN);

    guard = 0;
    while ((busy || mon_active || frame_q.size() != 0) && guard < 30000) begin
      @(negedge clk); guard++;
    end
    checkOutput("drain_busy", busy, 0);
    checkOutput("frames_left", frame_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ldpc_decoder.md
LDPC_DECODER -- requirements
Module: ldpc_decoder

Interface
REQ-001 SHALL have parameter D_WID, default 6, LLR sample width.
REQ-002 SHALL have parameter N_LEN, default 9216, codeword length in samples.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous active-high reset; 1 = reset (name kept for codebase compatibility).
REQ-006 SHALL have port data_in  input  D_WID  LLR sample, two's complement, negative = bit 1.
REQ-007 SHALL have port sync_in  input  1  sample valid; high for N_LEN consecutive cycles per frame.
REQ-008 SHALL have port rate  input  1  0 = rate 1/2 (K=4608, M=4608), 1 = rate 3/4 (K=6912, M=2304).
REQ-009 SHALL have port max_iter  input  5  maximum number of correcting passes.
REQ-010 SHALL have port data_out  output  1  decoded info bit.
REQ-011 SHALL have port sync_out  output  1  data_out valid.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port num_iter  output  5  correcting passes used by the last decoded frame.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> DECODE -> OUTPUT -> IDLE.
REQ-015 IDLE: first cycle with sync_in=1 stores sample 0, latches rate and max_iter, enters LOAD, sets busy=1 from the next cycle.
REQ-016 LOAD: stores one sample per cycle while sync_in=1; hard bit = sign bit; magnitude = |LLR|, with -32 giving 32.
REQ-017 LOAD: sync_in=0 before N_LEN samples SHALL abort the frame (no output, num_iter unchanged) and return to IDLE with busy=0.
REQ-018 SHALL ignore sync_in and data_in in DECODE and OUTPUT.
REQ-019 Parity structure: check j (0..M-1) SHALL cover bits j, j+M, j+2M, ... below N_LEN (degree 2 or 4).
REQ-020 A pass SHALL visit checks 0..M-1 in order; an odd-parity check flips the hard bit of its minimum-magnitude member (lowest index on tie); each pass takes exactly N_LEN+M cycles.
REQ-021 A pass with at least one flip SHALL increment the iteration count; DECODE ends when the count equals max_iter or per REQ-029/030; max_iter=0 SHALL skip DECODE.
REQ-022 OUTPUT: data_out SHALL carry hard bits 0..K-1, one per cycle, with sync_out=1 for exactly K contiguous cycles.
REQ-023 The first sync_out SHALL occur P*(N_LEN+M)+2 cycles after the last accepted sample, where P = passes run.
REQ-024 num_iter SHALL update on the first OUTPUT cycle and hold until the next frame's update.
REQ-025 busy SHALL go 0 on the cycle after the last sync_out; a sync_in high in that same cycle SHALL start a new frame.
REQ-026 data_out SHALL be 0 whenever sync_out=0.

Reset
REQ-027 While reset_n=1 at a clock edge: state=IDLE, busy=0, sync_out=0, data_out=0, num_iter=0, sample/pass/iteration counters=0.
REQ-028 Reset mid-frame SHALL discard the frame; stored memory contents need not be cleared.

Configuration
REQ-029 With macro LDPC_EARLY_STOP_EN defined, DECODE SHALL stop after the first pass with no failing check (P = num_iter+1, or num_iter if max_iter is reached).
REQ-030 Without LDPC_EARLY_STOP_EN, DECODE SHALL always run max_iter passes, and num_iter SHALL equal max_iter.

Verification (LDPC_EARLY_STOP_EN defined unless stated)
REQ-031 rate=0, max_iter=20, all samples +20 -> 4608 zeros on data_out, num_iter=0, busy low after the last bit.
REQ-032 rate=0, all +20 except sample 5 = -3 -> check 5 odd, bit 5 flipped, 4608 zeros out, num_iter=1.
REQ-033 rate=1, all +20 except sample 100 = -31 and sample 2404 = +1 -> bit 2404 flipped; output 6912 bits with ones only at 100 and 2404; num_iter=1.
REQ-034 max_iter=0, rate=0, sample 7 = -1 -> raw hard bits out (bit 7 = 1), num_iter=0, first sync_out 2 cycles after the last sample.
REQ-035 sync_in dropped after 100 samples -> no sync_out, busy=0 next cycle; a following full all +20 frame decodes to zeros.
REQ-036 reset_n pulsed during OUTPUT -> sync_out=0, data_out=0, busy=0, num_iter=0 on the next cycle; without the macro, repeat REQ-031 and expect num_iter=20.
